// File: rtl/aclk_alarm_ctrl.sv
// Alarm-operation engine: holds the programmed alarm time, detects the HH:MM:00 match
// against the timekeeper, and rings for a bounded time unless stopped or disabled.
module aclk_alarm_ctrl #(
  parameter int TICKS_PER_SEC = 10,
  parameter int RING_SECS     = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       AL_ON,
  input  logic       STOP_al,
  input  logic       LD_alarm,
  input  logic [4:0] H_in,
  input  logic [5:0] M_in,
  input  logic [4:0] CUR_H,
  input  logic [5:0] CUR_M,
  input  logic [5:0] CUR_S,
  output logic       Alarm,
  output logic [1:0] AL_STATE
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ARMED    = 2'd1,
    S_RINGING  = 2'd2,
    S_SILENCED = 2'd3
  } state_t;

  localparam int            PW        = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);
  localparam logic [PW-1:0] PRESC_ONE = PW'(1);
  localparam logic [7:0]    RING_LIM  = 8'(RING_SECS);

  // Reset asserts asynchronously everywhere, releases two clk edges after rst_n rises.
  logic rst_meta_q, rst_sync_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  state_t        state_q, state_d;
  logic [4:0]    al_h_q, al_h_d;
  logic [5:0]    al_m_q, al_m_d;
  logic          match_d_q, match_d_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    ring_q, ring_d;

  logic match, match_rise, sec_tick, timeout, load_ok, entering_ring;

  always_comb begin
    match      = (CUR_H == al_h_q) && (CUR_M == al_m_q) && (CUR_S == 6'd0);
    match_rise = match && !match_d_q;
    sec_tick   = (presc_q == PRESC_MAX);
    // Leave on the tick that brings the timer to RING_SECS, so the ring lasts exactly
    // RING_SECS full seconds from the entry edge.
    timeout    = (sec_tick && ((ring_q + 8'd1) == RING_LIM)) || (ring_q >= RING_LIM);
    load_ok    = LD_alarm && (H_in <= 5'd23) && (M_in <= 6'd59);

    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (AL_ON) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (!AL_ON)          state_d = S_IDLE;
        else if (match_rise) state_d = S_RINGING;
      end
      S_RINGING: begin
        if (!AL_ON)                  state_d = S_IDLE;
        else if (STOP_al || timeout) state_d = S_SILENCED;
      end
      S_SILENCED: begin
        if (!AL_ON)      state_d = S_IDLE;
        else if (!match) state_d = S_ARMED;
      end
      default: state_d = S_IDLE;
    endcase

    entering_ring = (state_q != S_RINGING) && (state_d == S_RINGING);

    al_h_d    = load_ok ? H_in : al_h_q;
    al_m_d    = load_ok ? M_in : al_m_q;
    match_d_d = match;

    if (entering_ring || sec_tick) presc_d = '0;
    else                           presc_d = presc_q + PRESC_ONE;

    ring_d = ring_q;
    if (entering_ring)
      ring_d = 8'd0;
    else if ((state_q == S_RINGING) && sec_tick && (ring_q != 8'hFF))
      ring_d = ring_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      state_q   <= S_IDLE;
      al_h_q    <= 5'd0;
      al_m_q    <= 6'd0;
      match_d_q <= 1'b0;
      presc_q   <= '0;
      ring_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      al_h_q    <= al_h_d;
      al_m_q    <= al_m_d;
      match_d_q <= match_d_d;
      presc_q   <= presc_d;
      ring_q    <= ring_d;
    end
  end

  assign Alarm    = (state_q == S_RINGING);
  assign AL_STATE = state_q;

endmodule

// File: tb/tb_aclk_alarm_ctrl.sv
// Directed bench for aclk_alarm_ctrl: each driven cycle queues the expected {Alarm, AL_STATE}
// after the next edge; a monitor pops and compares just after every rising edge.
module tb_aclk_alarm_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       AL_ON, STOP_al, LD_alarm;
  logic [4:0] H_in, CUR_H;
  logic [5:0] M_in, CUR_M, CUR_S;
  logic       Alarm;
  logic [1:0] AL_STATE;

  int n_checks = 0;
  int n_errors = 0;
  logic [2:0] exp_q[$];

  aclk_alarm_ctrl #(.TICKS_PER_SEC(10), .RING_SECS(3)) dut (
    .clk(clk), .rst_n(rst_n), .AL_ON(AL_ON), .STOP_al(STOP_al), .LD_alarm(LD_alarm),
    .H_in(H_in), .M_in(M_in), .CUR_H(CUR_H), .CUR_M(CUR_M), .CUR_S(CUR_S),
    .Alarm(Alarm), .AL_STATE(AL_STATE)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  // scoreboard monitor
  always @(posedge clk) begin
    logic [2:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({Alarm, AL_STATE} !== e) begin
        n_errors++;
        $display("FAIL cycle_check t=%0t: got Alarm=%0b AL_STATE=%0d, want Alarm=%0b AL_STATE=%0d",
                 $time, Alarm, AL_STATE, e[2], e[1:0]);
      end
    end
  end

  // driver tasks
  task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    CUR_H = h; CUR_M = m; CUR_S = s;
  endtask

  task automatic cyc(input logic exp_al, input logic [1:0] exp_st);
    exp_q.push_back({exp_al, exp_st});
    @(posedge clk);
    #2;
    LD_alarm = 1'b0;
    STOP_al  = 1'b0;
  endtask

  task automatic cyc_n(input int n, input logic exp_al, input logic [1:0] exp_st);
    for (int i = 0; i < n; i++) cyc(exp_al, exp_st);
  endtask

  task automatic load(input logic [4:0] h, input logic [5:0] m);
    LD_alarm = 1'b1; H_in = h; M_in = m;
  endtask

  task automatic check_now(input string name, input logic exp_al, input logic [1:0] exp_st);
    n_checks++;
    if ({Alarm, AL_STATE} !== {exp_al, exp_st}) begin
      n_errors++;
      $display("FAIL %s: got Alarm=%0b AL_STATE=%0d, want Alarm=%0b AL_STATE=%0d",
               name, Alarm, AL_STATE, exp_al, exp_st);
    end
  endtask

  initial begin
    rst_n = 1'b0; AL_ON = 1'b0; STOP_al = 1'b0; LD_alarm = 1'b0;
    H_in = 5'd0; M_in = 6'd0;
    set_time(5'd12, 6'd0, 6'd10);
    @(posedge clk); #2;
    check_now("reset_state", 1'b0, 2'd0);
    rst_n = 1'b1;
    cyc_n(3, 1'b0, 2'd0);

    // STOP_al in IDLE does nothing; default alarm time is 00:00
    STOP_al = 1'b1; cyc(1'b0, 2'd0);
    AL_ON = 1'b1; set_time(5'd23, 6'd59, 6'd59); cyc(1'b0, 2'd1);
    STOP_al = 1'b1; cyc(1'b0, 2'd1);
    set_time(5'd0, 6'd0, 6'd0); cyc(1'b1, 2'd2);

    // 1: async reset mid-ring, no clock edge involved
    #1 rst_n = 1'b0;
    #1 check_now("async_reset_mid_ring", 1'b0, 2'd0);
    AL_ON = 1'b0; set_time(5'd23, 6'd59, 6'd59);
    cyc(1'b0, 2'd0);
    rst_n = 1'b1;
    cyc_n(3, 1'b0, 2'd0);
    AL_ON = 1'b1; cyc(1'b0, 2'd1);
    set_time(5'd0, 6'd0, 6'd0); cyc(1'b1, 2'd2);
    STOP_al = 1'b1; cyc(1'b0, 2'd3);
    AL_ON = 1'b0; cyc(1'b0, 2'd0);

    // 2: load 07:30, ring, stop at 07:30:05, re-arm at 07:31:00
    load(5'd7, 6'd30); cyc(1'b0, 2'd0);
    AL_ON = 1'b1; set_time(5'd7, 6'd29, 6'd59); cyc(1'b0, 2'd1);
    set_time(5'd7, 6'd30, 6'd0); cyc(1'b1, 2'd2);
    for (int s = 1; s < 5; s++) begin
      set_time(5'd7, 6'd30, 6'(s)); cyc(1'b1, 2'd2);
    end
    set_time(5'd7, 6'd30, 6'd5); STOP_al = 1'b1; cyc(1'b0, 2'd3);
    set_time(5'd7, 6'd31, 6'd0); cyc(1'b0, 2'd1);

    // 4: invalid loads keep 07:30; valid load while ringing keeps ringing
    load(5'd24, 6'd15); cyc(1'b0, 2'd1);
    load(5'd7, 6'd60);  cyc(1'b0, 2'd1);
    set_time(5'd7, 6'd29, 6'd59); cyc(1'b0, 2'd1);
    set_time(5'd7, 6'd30, 6'd0);  cyc(1'b1, 2'd2);
    load(5'd8, 6'd0); set_time(5'd7, 6'd30, 6'd1); cyc(1'b1, 2'd2);
    STOP_al = 1'b1; set_time(5'd7, 6'd30, 6'd2); cyc(1'b0, 2'd3);
    set_time(5'd7, 6'd30, 6'd3); cyc(1'b0, 2'd1);
    set_time(5'd8, 6'd0, 6'd0); cyc(1'b1, 2'd2);
    STOP_al = 1'b1; set_time(5'd8, 6'd0, 6'd1); cyc(1'b0, 2'd3);
    load(5'd7, 6'd30); cyc(1'b0, 2'd1);

    // 3: no stop -> exactly 30 cycles high, then SILENCED while match holds
    set_time(5'd7, 6'd29, 6'd59); cyc(1'b0, 2'd1);
    set_time(5'd7, 6'd30, 6'd0);
    cyc_n(30, 1'b1, 2'd2);
    cyc_n(4, 1'b0, 2'd3);
    set_time(5'd7, 6'd30, 6'd1); cyc(1'b0, 2'd1);

    // 5: hold the match for 25 cycles, stop at cycle 3, no retrigger
    set_time(5'd7, 6'd29, 6'd59); cyc(1'b0, 2'd1);
    set_time(5'd7, 6'd30, 6'd0);
    cyc_n(2, 1'b1, 2'd2);
    STOP_al = 1'b1; cyc(1'b0, 2'd3);
    cyc_n(22, 1'b0, 2'd3);
    AL_ON = 1'b0; cyc(1'b0, 2'd0);
    AL_ON = 1'b1; cyc_n(4, 1'b0, 2'd1);
    // AL_ON rise together with match_rise: arm only
    AL_ON = 1'b0; set_time(5'd7, 6'd29, 6'd59); cyc(1'b0, 2'd0);
    AL_ON = 1'b1; set_time(5'd7, 6'd30, 6'd0);  cyc_n(3, 1'b0, 2'd1);

    // 6: AL_ON=0 with STOP_al while ringing -> IDLE
    set_time(5'd7, 6'd29, 6'd59); cyc(1'b0, 2'd1);
    set_time(5'd7, 6'd30, 6'd0);  cyc(1'b1, 2'd2);
    AL_ON = 1'b0; STOP_al = 1'b1; cyc(1'b0, 2'd0);
    cyc(1'b0, 2'd0);

    // final report
    @(posedge clk); #3;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations never compared, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
